// File: rtl/fx2_slave_fifo_model.sv
`default_nettype none
// ============================================================================
// Module : fx2_slave_fifo_model
// Brief  : Cypress FX2 slave-FIFO model, EP2 (host to FPGA) and EP6 (FPGA to host)
// Rev    : 1.0
// ============================================================================
module fx2_slave_fifo_model #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] cy_data,
  input  logic [1:0]  cy_addr,
  input  logic        cy_slrd_n,
  input  logic        cy_slwr_n,
  input  logic        cy_sloe_n,
  input  logic        cy_pkend_n,
  output logic        cy_flaga,
  output logic        cy_flagb,
  input  logic        host_wr_en,
  input  logic [15:0] host_wr_data,
  output logic        host_wr_full,
  input  logic        host_rd_en,
  output logic [15:0] host_rd_data,
  output logic        host_rd_empty,
  output logic        pkt_done,
  output logic [15:0] pkt_len,
  output logic [2:0]  err
);

  localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);
  localparam logic [1:0]  C_EP2  = 2'b00;
  localparam logic [1:0]  C_EP6  = 2'b10;

  logic [15:0]   ep2_mem_q [DEPTH];
  logic [15:0]   ep6_mem_q [DEPTH];

  logic [AW-1:0] ep2_wp_q, ep2_wp_d, ep2_rp_q, ep2_rp_d;
  logic [AW-1:0] ep6_wp_q, ep6_wp_d, ep6_rp_q, ep6_rp_d;
  logic [AW:0]   ep2_cnt_q, ep2_cnt_d, ep6_cnt_q, ep6_cnt_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic [15:0]   pkt_len_q, pkt_len_d;
  logic          pkt_done_q, pkt_done_d;
  logic [2:0]    err_q, err_d;

  logic          ep2_empty, ep2_full, ep6_empty, ep6_full;
  logic          fpga_rd, fpga_wr, conflict, pkend;
  logic          ep2_push, ep2_pop, ep6_push, ep6_pop;
  logic          bus_oe;
  logic [15:0]   pkt_inc;

  assign ep2_empty = (ep2_cnt_q == '0);
  assign ep2_full  = (ep2_cnt_q == C_FULL);
  assign ep6_empty = (ep6_cnt_q == '0);
  assign ep6_full  = (ep6_cnt_q == C_FULL);

  // Strobes at the unused addresses 01/11 fall through every decode below.
  assign fpga_rd  = !cy_slrd_n && (cy_addr == C_EP2);
  assign fpga_wr  = !cy_slwr_n && (cy_addr == C_EP6);
  assign conflict = !cy_slwr_n && !cy_sloe_n && !cy_addr[0];
  assign pkend    = !cy_pkend_n && (cy_addr == C_EP6);

  assign ep2_pop  = fpga_rd && !ep2_empty;
  assign ep2_push = host_wr_en && !ep2_full;
  assign ep6_push = fpga_wr && cy_sloe_n && !ep6_full;
  assign ep6_pop  = host_rd_en && !ep6_empty;

  assign pkt_inc  = (ep6_push && (pkt_cnt_q != 16'hFFFF)) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;

  always_comb begin
    ep2_wp_d   = ep2_wp_q;
    ep2_rp_d   = ep2_rp_q;
    ep2_cnt_d  = ep2_cnt_q;
    ep6_wp_d   = ep6_wp_q;
    ep6_rp_d   = ep6_rp_q;
    ep6_cnt_d  = ep6_cnt_q;
    pkt_cnt_d  = pkt_inc;
    pkt_len_d  = pkt_len_q;
    pkt_done_d = 1'b0;
    err_d      = err_q | {conflict, fpga_wr && cy_sloe_n && ep6_full, fpga_rd && ep2_empty};

    if (ep2_push) ep2_wp_d = ep2_wp_q + 1'b1;
    if (ep2_pop)  ep2_rp_d = ep2_rp_q + 1'b1;
    case ({ep2_push, ep2_pop})
      2'b10:   ep2_cnt_d = ep2_cnt_q + 1'b1;
      2'b01:   ep2_cnt_d = ep2_cnt_q - 1'b1;
      default: ep2_cnt_d = ep2_cnt_q;
    endcase

    if (ep6_push) ep6_wp_d = ep6_wp_q + 1'b1;
    if (ep6_pop)  ep6_rp_d = ep6_rp_q + 1'b1;
    case ({ep6_push, ep6_pop})
      2'b10:   ep6_cnt_d = ep6_cnt_q + 1'b1;
      2'b01:   ep6_cnt_d = ep6_cnt_q - 1'b1;
      default: ep6_cnt_d = ep6_cnt_q;
    endcase

    // The committed length includes a word accepted on the pkend edge itself.
    if (pkend) begin
      pkt_done_d = 1'b1;
      pkt_len_d  = pkt_inc;
      pkt_cnt_d  = 16'h0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ep2_wp_q   <= '0;
      ep2_rp_q   <= '0;
      ep2_cnt_q  <= '0;
      ep6_wp_q   <= '0;
      ep6_rp_q   <= '0;
      ep6_cnt_q  <= '0;
      pkt_cnt_q  <= 16'h0000;
      pkt_len_q  <= 16'h0000;
      pkt_done_q <= 1'b0;
      err_q      <= 3'b000;
    end else begin
      ep2_wp_q   <= ep2_wp_d;
      ep2_rp_q   <= ep2_rp_d;
      ep2_cnt_q  <= ep2_cnt_d;
      ep6_wp_q   <= ep6_wp_d;
      ep6_rp_q   <= ep6_rp_d;
      ep6_cnt_q  <= ep6_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pkt_len_q  <= pkt_len_d;
      pkt_done_q <= pkt_done_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: the counts alone decide which words are live.
  always_ff @(posedge clk) begin
    if (ep2_push) ep2_mem_q[ep2_wp_q] <= host_wr_data;
    if (ep6_push) ep6_mem_q[ep6_wp_q] <= cy_data;
  end

  assign bus_oe  = !cy_sloe_n && (cy_addr == C_EP2) && cy_slwr_n;
  assign cy_data = bus_oe ? (ep2_empty ? 16'h0000 : ep2_mem_q[ep2_rp_q]) : 16'hzzzz;

  assign cy_flaga      = !ep2_empty;
  assign cy_flagb      = !ep6_full;
  assign host_wr_full  = ep2_full;
  assign host_rd_empty = ep6_empty;
  assign host_rd_data  = ep6_mem_q[ep6_rp_q];
  assign pkt_done      = pkt_done_q;
  assign pkt_len       = pkt_len_q;
  assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fx2_slave_fifo_model.sv
`default_nettype none
// Bench for fx2_slave_fifo_model: queue-based reference model feeding a scoreboard,
// directed scenarios followed by randomized traffic.
module tb_fx2_slave_fifo_model;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [15:0] cy_data;
  logic [1:0]  cy_addr;
  logic        cy_slrd_n, cy_slwr_n, cy_sloe_n, cy_pkend_n;
  logic        cy_flaga, cy_flagb;
  logic        host_wr_en, host_wr_full;
  logic [15:0] host_wr_data;
  logic        host_rd_en, host_rd_empty;
  logic [15:0] host_rd_data;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic [2:0]  err;
  logic [15:0] tb_dat;

  int checks = 0;
  int errors = 0;

  logic [15:0] ep2[$];
  logic [15:0] ep6[$];
  logic [15:0] exp_bus[$];
  logic [15:0] exp_rd[$];
  logic [15:0] exp_pkt[$];
  int          pkt_cnt;
  logic [2:0]  m_err;

  fx2_slave_fifo_model #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cy_data(cy_data), .cy_addr(cy_addr),
    .cy_slrd_n(cy_slrd_n), .cy_slwr_n(cy_slwr_n), .cy_sloe_n(cy_sloe_n),
    .cy_pkend_n(cy_pkend_n), .cy_flaga(cy_flaga), .cy_flagb(cy_flagb),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data), .host_wr_full(host_wr_full),
    .host_rd_en(host_rd_en), .host_rd_data(host_rd_data), .host_rd_empty(host_rd_empty),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .err(err)
  );

  always #5 clk = ~clk;

  assign cy_data = (!cy_slwr_n && cy_addr == 2'b10) ? tb_dat : 16'hzzzz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Status vector: {pkt_done, flaga, flagb, wr_full, rd_empty, err[2:0]}
  task automatic check_state(input string nm, input logic exp_done);
    chk(nm, {24'd0, pkt_done, cy_flaga, cy_flagb, host_wr_full, host_rd_empty, err},
        {24'd0, exp_done, ep2.size() != 0, ep6.size() != DEPTH,
         ep2.size() == DEPTH, ep6.size() == 0, m_err});
  endtask

  task automatic idle();
    host_wr_en = 1'b0; host_rd_en = 1'b0;
    cy_addr = 2'b01; cy_slrd_n = 1'b1; cy_slwr_n = 1'b1;
    cy_sloe_n = 1'b1; cy_pkend_n = 1'b1;
  endtask

  task automatic clear_model();
    ep2.delete(); ep6.delete(); pkt_cnt = 0; m_err = 3'b000;
  endtask

  task automatic apply_reset();
    idle(); rst = 1'b1; clear_model();
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // One clock of stimulus: expectations queued before the edge, model advanced at it.
  task automatic step(input string nm);
    int   n2, n6;
    logic pk;
    n2 = ep2.size(); n6 = ep6.size(); pk = 1'b0;
    if (!cy_sloe_n && cy_addr == 2'b00 && cy_slwr_n)
      exp_bus.push_back(n2 != 0 ? ep2[0] : 16'h0000);
    if (host_rd_en && n6 != 0) exp_rd.push_back(ep6[0]);
    @(posedge clk);
    if (!cy_slrd_n && cy_addr == 2'b00) begin
      if (n2 != 0) void'(ep2.pop_front());
      else m_err[0] = 1'b1;
    end
    if (host_wr_en && n2 < DEPTH) ep2.push_back(host_wr_data);
    if (!cy_slwr_n && !cy_sloe_n && (cy_addr == 2'b00 || cy_addr == 2'b10)) m_err[2] = 1'b1;
    if (!cy_slwr_n && cy_sloe_n && cy_addr == 2'b10) begin
      if (n6 < DEPTH) begin
        ep6.push_back(tb_dat);
        if (pkt_cnt < 65535) pkt_cnt++;
      end else m_err[1] = 1'b1;
    end
    if (host_rd_en && n6 != 0) void'(ep6.pop_front());
    if (!cy_pkend_n && cy_addr == 2'b10) begin
      exp_pkt.push_back(16'(pkt_cnt));
      pkt_cnt = 0;
      pk = 1'b1;
    end
    #1;
    check_state(nm, pk);
  endtask

  task automatic fpga_write(input logic [15:0] d, input logic pk);
    cy_addr = 2'b10; cy_sloe_n = 1'b1; cy_slwr_n = 1'b0; cy_slrd_n = 1'b1;
    cy_pkend_n = !pk; tb_dat = d;
  endtask

  task automatic fpga_read();
    cy_addr = 2'b00; cy_sloe_n = 1'b0; cy_slrd_n = 1'b0; cy_slwr_n = 1'b1; cy_pkend_n = 1'b1;
  endtask

  // Scoreboard monitor: consumes an expectation whenever the DUT presents data.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!cy_sloe_n && cy_addr == 2'b00 && cy_slwr_n) begin
          if (exp_bus.size() == 0) chk("bus_unexpected", 1, 0);
          else begin e = exp_bus.pop_front(); chk("cy_data", {16'd0, cy_data}, {16'd0, e}); end
        end
        if (host_rd_en && !host_rd_empty) begin
          if (exp_rd.size() == 0) chk("host_rd_unexpected", 1, 0);
          else begin e = exp_rd.pop_front(); chk("host_rd_data", {16'd0, host_rd_data}, {16'd0, e}); end
        end
        if (pkt_done) begin
          if (exp_pkt.size() == 0) chk("pkt_done_unexpected", 1, 0);
          else begin e = exp_pkt.pop_front(); chk("pkt_len", {16'd0, pkt_len}, {16'd0, e}); end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    idle(); host_wr_data = 16'h0000; tb_dat = 16'h0000; clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset_state", 1'b0);
    chk("reset_pkt_len", {16'd0, pkt_len}, 0);
    cy_sloe_n = 1'b0; cy_addr = 2'b00; #1;
    chk("reset_bus", {16'd0, cy_data}, 0);
    idle();
    @(posedge clk); #1; rst = 1'b0;

    // Host loads two words; FPGA reads them back across the bus.
    host_wr_en = 1'b1; host_wr_data = 16'h4C4F; step("load0");
    host_wr_data = 16'h5044; step("load1");
    host_wr_en = 1'b0; fpga_read(); step("ep2_rd0"); step("ep2_rd1");
    step("ep2_underrun");
    idle(); step("idle0");

    // EP6 overflow then ordered host drain.
    apply_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin fpga_write(16'hA000 + 16'(i), 1'b0); step("ep6_fill"); end
    idle(); host_rd_en = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step("ep6_drain");
    idle(); step("idle1");

    // Packet commit: pkend coincident with the 4th write, then a zero-length packet.
    apply_reset();
    for (int i = 0; i < 3; i++) begin fpga_write(16'hC000 + 16'(i), 1'b0); step("pkt_wr"); end
    fpga_write(16'hC003, 1'b1); step("pkt_end4");
    fpga_write(16'h0000, 1'b0); cy_slwr_n = 1'b1; cy_pkend_n = 1'b0; step("pkt_end0");
    idle(); step("pkt_idle");

    // Simultaneous push/pop at EP2 full and at EP6 count 3.
    apply_reset();
    host_wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin host_wr_data = 16'hB000 + 16'(i); step("ep2_fill"); end
    host_wr_data = 16'hDEAD; fpga_read(); step("ep2_full_rw");
    host_wr_en = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) step("ep2_rd_rest");
    apply_reset();
    for (int i = 0; i < 3; i++) begin fpga_write(16'hE000 + 16'(i), 1'b0); step("ep6_three"); end
    fpga_write(16'hE003, 1'b0); host_rd_en = 1'b1; step("ep6_rw");
    idle(); host_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) step("ep6_rd_rest");
    idle(); step("idle2");

    // Asynchronous reset in the middle of a two-sided burst.
    apply_reset();
    host_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_wr_data = 16'h7000 + 16'(i); fpga_write(16'h7100 + 16'(i), 1'b0); step("burst");
    end
    #1; rst = 1'b1; clear_model(); #1;
    check_state("async_reset", 1'b0);
    idle(); cy_sloe_n = 1'b0; cy_addr = 2'b00; #1;
    chk("async_reset_bus", {16'd0, cy_data}, 0);
    idle();
    @(posedge clk); #1; rst = 1'b0;
    cy_addr = 2'b10; cy_sloe_n = 1'b0; cy_slwr_n = 1'b0; tb_dat = 16'h1234; step("conflict");
    idle(); step("idle3");

    // Randomized traffic against the reference model.
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      host_wr_en = 1'($urandom); host_wr_data = 16'($urandom);
      host_rd_en = 1'($urandom);
      r = $urandom_range(0, 39);
      if (r < 12) fpga_read();
      else if (r < 26) fpga_write(16'($urandom), $urandom_range(0, 7) == 0);
      else if (r < 29) begin cy_addr = 2'b10; cy_pkend_n = 1'b0; end
      else if (r < 33) begin cy_addr = 2'b00; cy_sloe_n = 1'b0; end
      else if (r < 34) begin cy_addr = 2'b10; cy_sloe_n = 1'b0; cy_slwr_n = 1'b0; tb_dat = 16'($urandom); end
      else if (r < 37) begin cy_addr = 2'b01; cy_slrd_n = 1'b0; end
      step("random");
    end
    idle(); step("final0"); step("final1");
    chk("scoreboard_drained", exp_bus.size() + exp_rd.size() + exp_pkt.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
